gen_fifo_sample_reader: RTL and testbench
=========================================

// Module: gen_fifo_sample_reader
// PURPOSE
//  Read side of the generator FIFO: pops samples written by the function generator and
//  presents them to the DAC front-end at a programmable sample rate.
//  Sits between the gen FIFO read port and the DAC interface; paces reads with a clock divider.
//  Flags underruns and holds the last sample so the output never glitches.
// PARAMETERS
//  DATA_WIDTH   16   sample width (signed, matches generator data_o)
//  DIV_WIDTH    16   width of sample-period divider
//  CNT_WIDTH    16   width of underrun counter (macro-enabled feature only)
// PORTS
//  clk             in   1           clock
//  rst             in   1           synchronous reset, active-high
//  en_i            in   1           streaming enable
//  div_i           in   DIV_WIDTH   sample period minus one, in clk cycles
//  fifo_empty_i    in   1           FIFO empty flag
//  fifo_data_i     in   DATA_WIDTH  FIFO read data; valid 1 cycle after fifo_rd_en_o
//  fifo_rd_en_o    out  1           FIFO pop strobe
//  sample_o        out  DATA_WIDTH  current DAC sample (signed)
//  sample_valid_o  out  1           1-cycle pulse when sample_o updates
//  underrun_o      out  1           1-cycle pulse: read point hit with FIFO empty
//  underrun_cnt_o  out  CNT_WIDTH   underrun count (only with GEN_FIFO_RD_UNDERRUN_CNT_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, divider cnt=0, fifo_rd_en_o=0, sample_o=0, sample_valid_o=0, underrun_o=0,
//    underrun_cnt_o=0, pending-capture flag cleared; reset mid-operation discards in-flight reads.
//  - FSM: IDLE -(en_i)-> PRIME -(en_i && !fifo_empty_i)-> RUN. Any state -(!en_i)-> IDLE.
//    PRIME waits for first data so start-up never reports underrun.
//  - RUN divider: cnt counts 0..div_i. Read point = cnt==0. If cnt>=div_i, next cnt=0, else cnt+1.
//    Period = div_i+1 cycles; div_i=0 gives a read point every cycle.
//    If div_i is lowered below cnt mid-period, cnt wraps to 0 on the next cycle.
//    Entering RUN loads cnt=0, so first read point is the first RUN cycle.
//  - Read point with !fifo_empty_i: fifo_rd_en_o=1 that cycle (combinational from state/cnt/empty).
//    Next cycle: sample_o<=fifo_data_i, sample_valid_o=1. Latency rd_en->sample_o = 1 cycle.
//  - Read point with fifo_empty_i: no pop, underrun_o=1 for that cycle, sample_o holds last value,
//    sample_valid_o=0. FSM stays in RUN.
//  - fifo_rd_en_o is never asserted when fifo_empty_i=1, outside RUN, or when en_i=0.
//  - en_i dropping on a read point: no pop issued. A pop issued the previous cycle still completes.
//    Its capture and sample_valid_o pulse occur even in IDLE; popped data is never lost.
//  - sample_o holds its value in IDLE and PRIME (no return to 0 except on rst).
// CONFIGURATION
//  - GEN_FIFO_RD_UNDERRUN_CNT_EN defined: underrun_cnt_o port exists.
//    It increments on each underrun_o pulse and saturates at 2**CNT_WIDTH-1.
//    It is cleared only by rst, not by en_i.
//  - Not defined: port and counter absent; underrun_o pulse still generated.
// STRUCTURE
//  - gen_fifo_defines_pkg gains: typedef enum logic [1:0] {RD_IDLE, RD_PRIME, RD_RUN} rd_state_e;
//    RD_RESET_SAMPLE constant ('0); reuse existing `DATA_WIDTH define for the default.
//  - One sub-module: gen_fifo_rate_divider.
//    Ports: clk, rst, clr_i, div_i, tick_o. Counter with >= wrap compare; tick_o = (cnt==0).
//  - Top holds FSM, pop gating, capture register, underrun logic.
// TESTING
//  1) rst, en_i=1, div_i=3, FIFO preloaded 0x0001..0x0004.
//     Pops every 4 cycles; sample_o=1,2,3,4; sample_valid_o 1 cycle after each fifo_rd_en_o.
//  2) div_i=0, 8 entries preloaded -> fifo_rd_en_o high 8 consecutive cycles, 8 back-to-back valids.
//     No pop when empty rises.
//  3) Start with empty FIFO, en_i=1 -> stays PRIME, no underrun_o.
//     Write 0x7FFF -> pop on first RUN cycle, sample_o=0x7FFF.
//  4) RUN, div_i=2, FIFO drains after 0x8000.
//     Next read point: underrun_o=1, sample_o holds 0x8000, no pop.
//     With macro: underrun_cnt_o increments by 1 per read point; forced to 2**CNT_WIDTH-1, stays saturated.
//  5) Drop en_i the cycle after a pop -> sample captured and valid pulses; FSM IDLE, no further pops.
//     Drop en_i on a read point -> no pop.
//  6) div_i 10->2 while cnt=7 -> cnt=0 next cycle, then period 3.
//     Assert rst mid-run -> all outputs 0 next cycle; pending capture discarded.

Source files
------------

// File: rtl/gen_fifo_defines_pkg.sv
// Shared types and constants for the generator FIFO read side.
// Sample width defaults to the codebase `DATA_WIDTH define.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package gen_fifo_defines_pkg;

   localparam int GEN_DATA_WIDTH = `DATA_WIDTH;
   localparam int GEN_DIV_WIDTH  = 16;
`ifdef GEN_FIFO_RD_UNDERRUN_CNT_EN
   localparam int GEN_CNT_WIDTH  = 16;
`endif

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_PRIME,
      RD_RUN
   } rd_state_e;

   localparam logic [GEN_DATA_WIDTH-1:0] RD_RESET_SAMPLE = '0;

endpackage

// File: rtl/gen_fifo_rate_divider.sv
// Sample-rate divider for the gen FIFO reader.
// Counts 0..div_i and ticks on zero; a lowered div_i wraps at once.
module gen_fifo_rate_divider
   import gen_fifo_defines_pkg::*;
#(
   parameter int DIV_WIDTH = GEN_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic                 tick_o
);

   logic [DIV_WIDTH-1:0] cnt;

   // Period counter; >= compare so a shrinking period never overruns
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         cnt <= '0;
      end else if (cnt >= div_i) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_WIDTH'(1);
      end
   end

   assign tick_o = (cnt == '0);

endmodule

// File: rtl/gen_fifo_sample_reader.sv
// Gen FIFO read side: paces pops to the DAC, flags underruns, holds last sample.
// Optional underrun counter port: define GEN_FIFO_RD_UNDERRUN_CNT_EN.
module gen_fifo_sample_reader
   import gen_fifo_defines_pkg::*;
#(
   parameter int DATA_WIDTH = GEN_DATA_WIDTH,
   parameter int DIV_WIDTH  = GEN_DIV_WIDTH
`ifdef GEN_FIFO_RD_UNDERRUN_CNT_EN
   ,
   parameter int CNT_WIDTH  = GEN_CNT_WIDTH
`endif
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en_i,
   input  logic [DIV_WIDTH-1:0]         div_i,
   input  logic                         fifo_empty_i,
   input  logic [DATA_WIDTH-1:0]        fifo_data_i,
   output logic                         fifo_rd_en_o,
   output logic signed [DATA_WIDTH-1:0] sample_o,
   output logic                         sample_valid_o,
   output logic                         underrun_o
`ifdef GEN_FIFO_RD_UNDERRUN_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]         underrun_cnt_o
`endif
);

   rd_state_e state;
   rd_state_e state_nxt;

   logic tick;
   logic div_clr;
   logic pending;
   logic signed [DATA_WIDTH-1:0] held;

   gen_fifo_rate_divider #(
      .DIV_WIDTH(DIV_WIDTH)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .clr_i (div_clr),
      .div_i (div_i),
      .tick_o(tick)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RD_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: PRIME waits for first data; dropping en_i always idles
   always_comb begin
      state_nxt = state;
      unique case (state)
         RD_IDLE: begin
            if (en_i) begin
               state_nxt = RD_PRIME;
            end
         end
         RD_PRIME: begin
            if (!fifo_empty_i) begin
               state_nxt = RD_RUN;
            end
         end
         RD_RUN: begin
            state_nxt = RD_RUN;
         end
         default: begin
            state_nxt = RD_IDLE;
         end
      endcase
      if (!en_i) begin
         state_nxt = RD_IDLE;
      end
   end

   // Outputs: divider held clear outside RUN; read point pops or underruns
   always_comb begin
      div_clr      = 1'b1;
      fifo_rd_en_o = 1'b0;
      underrun_o   = 1'b0;
      unique case (state)
         RD_RUN: begin
            div_clr = 1'b0;
            if (en_i && tick) begin
               fifo_rd_en_o = !fifo_empty_i;
               underrun_o   = fifo_empty_i;
            end
         end
         default: begin
            div_clr = 1'b1;
         end
      endcase
   end

   // Capture tracking: a pop always completes, even if en_i has dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
         held    <= DATA_WIDTH'(RD_RESET_SAMPLE);
      end else begin
         pending <= fifo_rd_en_o;
         if (pending) begin
            held <= fifo_data_i;
         end
      end
   end

   // Popped word shows the cycle its FIFO read data is valid, then is held
   always_comb begin
      sample_o = held;
      if (pending) begin
         sample_o = fifo_data_i;
      end
   end

   assign sample_valid_o = pending;

`ifdef GEN_FIFO_RD_UNDERRUN_CNT_EN
   // Saturating underrun counter, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         underrun_cnt_o <= '0;
      end else if (underrun_o && (underrun_cnt_o != '1)) begin
         underrun_cnt_o <= underrun_cnt_o + CNT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_gen_fifo_sample_reader.sv
// Bench for gen_fifo_sample_reader: FIFO model plus per-scenario checks.
// Underrun counter checks are built in with GEN_FIFO_RD_UNDERRUN_CNT_EN.
module tb_gen_fifo_sample_reader;

   localparam int DW = 16;
   localparam int VW = 16;
`ifdef GEN_FIFO_RD_UNDERRUN_CNT_EN
   localparam int CW = 4;
   localparam int SAT_EXTRA = 20;
`else
   localparam int SAT_EXTRA = 2;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic [VW-1:0] div = '0;
   logic fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data = '0;
   logic rd_en;
   logic signed [DW-1:0] sample;
   logic valid;
   logic underrun;
`ifdef GEN_FIFO_RD_UNDERRUN_CNT_EN
   logic [CW-1:0] un_cnt;
`endif

   logic wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic flush = 1'b1;
   logic [DW-1:0] fq[$];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   gen_fifo_sample_reader #(
      .DATA_WIDTH(DW),
      .DIV_WIDTH (VW)
`ifdef GEN_FIFO_RD_UNDERRUN_CNT_EN
      ,
      .CNT_WIDTH (CW)
`endif
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en_i          (en),
      .div_i         (div),
      .fifo_empty_i  (fifo_empty),
      .fifo_data_i   (fifo_data),
      .fifo_rd_en_o  (rd_en),
      .sample_o      (sample),
      .sample_valid_o(valid),
      .underrun_o    (underrun)
`ifdef GEN_FIFO_RD_UNDERRUN_CNT_EN
      ,
      .underrun_cnt_o(un_cnt)
`endif
   );

   // Synchronous FIFO model: registered read data, empty flag after the edge
   always @(posedge clk) begin
      if (flush) begin
         fq.delete();
         fifo_empty <= 1'b1;
         fifo_data  <= '0;
      end else begin
         if (rd_en && fq.size() != 0) begin
            fifo_data <= fq.pop_front();
         end
         if (wr_en) begin
            fq.push_back(wr_data);
         end
         fifo_empty <= (fq.size() == 0);
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      flush = 1'b1;
      en = 1'b0;
      wr_en = 1'b0;
      div = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      flush = 1'b0;
   endtask

   // Ends on a negedge with the FIFO holding all values
   task automatic preload(input logic [DW-1:0] vals[$]);
      foreach (vals[i]) begin
         @(negedge clk);
         wr_en = 1'b1;
         wr_data = vals[i];
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [DW-1:0] v[$];
      do_reset();
      v.push_back(16'h1234);
      v.push_back(16'h5678);
      preload(v);
      repeat (3) begin
         @(negedge clk);
         total++;
         if (rd_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_rd_en got=%b exp=0", rd_en);
         end
         total++;
         if (valid !== 1'b0 || underrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulses got=%b%b exp=00", valid, underrun);
         end
         total++;
         if (sample !== 16'sh0000) begin
            bad++;
            $display("FAIL reset_sample got=%h exp=0000", sample);
         end
`ifdef GEN_FIFO_RD_UNDERRUN_CNT_EN
         total++;
         if (un_cnt !== '0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d exp=0", un_cnt);
         end
`endif
      end
   endtask

   // Reference: from enable at k=0, read points at k=2+m*(d+1);
   // first n read points pop in order, later ones underrun;
   // each pop shows as valid+sample on the following cycle.
   task automatic test_stream(input string tag, input int n, input int d,
                              input int mode, input int extra);
      logic [DW-1:0] v[$];
      logic [DW-1:0] exp_s;
      int p;
      int uns;
      int kmax;
      int cmax;
      bit prev_pop;
      bit rp;
      bit e_rd;
      bit e_un;
      do_reset();
      for (int i = 0; i < n; i++) begin
         if (mode == 1) v.push_back(16'($urandom));
         else v.push_back(16'(i + 1));
      end
      if (mode == 2) v[n-1] = 16'h8000;
      preload(v);
      div = VW'(d);
      en = 1'b1;
      kmax = 3 + (n + 1 + extra) * (d + 1);
      p = 0;
      uns = 0;
      exp_s = '0;
      prev_pop = 1'b0;
      cmax = 0;
`ifdef GEN_FIFO_RD_UNDERRUN_CNT_EN
      cmax = (1 << CW) - 1;
`endif
      for (int k = 1; k <= kmax; k++) begin
         @(negedge clk);
         rp = (k >= 2) && (((k - 2) % (d + 1)) == 0);
         e_rd = rp && (p < n);
         e_un = rp && (p >= n);
         if (prev_pop) exp_s = v[p-1];
         total++;
         if (rd_en !== e_rd) begin
            bad++;
            $display("FAIL %s_rd_en k=%0d got=%b exp=%b", tag, k, rd_en, e_rd);
         end
         total++;
         if (underrun !== e_un) begin
            bad++;
            $display("FAIL %s_underrun k=%0d got=%b exp=%b", tag, k, underrun, e_un);
         end
         total++;
         if (valid !== prev_pop) begin
            bad++;
            $display("FAIL %s_valid k=%0d got=%b exp=%b", tag, k, valid, prev_pop);
         end
         total++;
         if (sample !== exp_s) begin
            bad++;
            $display("FAIL %s_sample k=%0d got=%h exp=%h", tag, k, sample, exp_s);
         end
`ifdef GEN_FIFO_RD_UNDERRUN_CNT_EN
         total++;
         if (un_cnt !== CW'(uns < cmax ? uns : cmax)) begin
            bad++;
            $display("FAIL %s_cnt k=%0d got=%0d exp=%0d", tag, k, un_cnt,
                     (uns < cmax ? uns : cmax));
         end
`endif
         if (e_un) uns++;
         if (e_rd) p++;
         prev_pop = e_rd;
      end
      en = 1'b0;
   endtask

   task automatic test_prime();
      do_reset();
      div = VW'(5);
      en = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         total++;
         if (rd_en !== 1'b0 || underrun !== 1'b0) begin
            bad++;
            $display("FAIL prime_idle k=%0d got=%b%b exp=00", k, rd_en, underrun);
         end
      end
      wr_en = 1'b1;
      wr_data = 16'h7FFF;
      @(negedge clk);
      wr_en = 1'b0;
      total++;
      if (rd_en !== 1'b0) begin
         bad++;
         $display("FAIL prime_early got=%b exp=0", rd_en);
      end
      @(negedge clk);
      total++;
      if (rd_en !== 1'b1) begin
         bad++;
         $display("FAIL prime_first_pop got=%b exp=1", rd_en);
      end
      @(negedge clk);
      total++;
      if (valid !== 1'b1 || sample !== 16'sh7FFF) begin
         bad++;
         $display("FAIL prime_sample got=%b/%h exp=1/7fff", valid, sample);
      end
      en = 1'b0;
   endtask

   task automatic test_en_drop();
      logic [DW-1:0] v[$];
      do_reset();
      v.push_back(16'hA5A5);
      v.push_back(16'h0F0F);
      v.push_back(16'h3C3C);
      preload(v);
      div = VW'(3);
      en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (rd_en !== 1'b1) begin
         bad++;
         $display("FAIL drop_pop got=%b exp=1", rd_en);
      end
      @(posedge clk);
      #1 en = 1'b0;
      @(negedge clk);
      total++;
      if (valid !== 1'b1 || sample !== 16'shA5A5) begin
         bad++;
         $display("FAIL drop_capture got=%b/%h exp=1/a5a5", valid, sample);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         total++;
         if (rd_en !== 1'b0 || valid !== 1'b0 || sample !== 16'shA5A5) begin
            bad++;
            $display("FAIL drop_idle k=%0d got=%b/%b/%h exp=0/0/a5a5",
                     k, rd_en, valid, sample);
         end
      end
      do_reset();
      preload(v);
      div = VW'(3);
      en = 1'b1;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 en = 1'b0;
      @(negedge clk);
      total++;
      if (rd_en !== 1'b0) begin
         bad++;
         $display("FAIL drop_on_read_point got=%b exp=0", rd_en);
      end
      @(negedge clk);
      total++;
      if (valid !== 1'b0 || sample !== 16'shA5A5) begin
         bad++;
         $display("FAIL drop_rp_hold got=%b/%h exp=0/a5a5", valid, sample);
      end
   endtask

   task automatic test_div_change();
      logic [DW-1:0] v[$];
      bit e;
      for (int i = 0; i < 4; i++) v.push_back(16'($urandom));
      do_reset();
      preload(v);
      div = VW'(10);
      en = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         if (k == 9) begin
            @(posedge clk);
            #1 div = VW'(2);
         end
         @(negedge clk);
         e = (k == 2) || (k == 10) || (k == 13);
         total++;
         if (rd_en !== e) begin
            bad++;
            $display("FAIL divchg_rd_en k=%0d got=%b exp=%b", k, rd_en, e);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] v[$];
      v.push_back(16'h4242);
      v.push_back(16'h1111);
      do_reset();
      preload(v);
      div = VW'(1);
      en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (rd_en !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_pop got=%b exp=1", rd_en);
      end
      rst = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      total++;
      if (rd_en !== 1'b0 || valid !== 1'b0 || underrun !== 1'b0 ||
          sample !== 16'sh0000) begin
         bad++;
         $display("FAIL rstmid_outputs got=%b%b%b/%h exp=000/0000",
                  rd_en, valid, underrun, sample);
      end
      rst = 1'b0;
      flush = 1'b0;
      en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream("paced", 4, 3, 0, 1);
      test_stream("b2b", 8, 0, 0, 1);
      test_prime();
      test_stream("underrun", 3, 2, 2, SAT_EXTRA);
      test_en_drop();
      test_div_change();
      test_reset_mid();
      for (int r = 0; r < 6; r++) begin
         test_stream("rand", int'($urandom_range(1, 6)),
                     int'($urandom_range(0, 5)), 1, 1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
